// File: rtl/ppg_afe_pkg.sv
// Shared types and default constants for the PPG AFE calibration controller.
package ppg_afe_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DC_CAL,
        PGA_CAL,
        NEXT_CH,
        RUN
    } cal_state_t;

    localparam int SAMPLE_CH_W   = 3;
    localparam int DEF_TARGET_LO = 120;
    localparam int DEF_TARGET_HI = 130;
    localparam int DEF_CLIP_LO   = 10;
    localparam int DEF_CLIP_HI   = 245;

endpackage

// File: rtl/ppg_window_stats.sv
// Windowed min/max tracker; statistics and window_done include the sample
// presented in the current cycle so the caller can act on the same edge.
module ppg_window_stats
    import ppg_afe_pkg::*;
#(
    parameter int ADC_W  = 8,
    parameter int WINDOW = 20
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             sample,
    input  logic [ADC_W-1:0] din,
    output logic             win_done,
    output logic [ADC_W-1:0] win_min,
    output logic [ADC_W-1:0] win_max,
    output logic [ADC_W-1:0] win_mid
);

    localparam int CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ADC_W-1:0] min_q, min_d;
    logic [ADC_W-1:0] max_q, max_d;

    always_comb begin
        win_min  = (sample && (din < min_q)) ? din : min_q;
        win_max  = (sample && (din > max_q)) ? din : max_q;
        win_done = sample && (cnt_q == CNT_W'(WINDOW - 1));
        // The sum needs one extra bit before halving.
        win_mid  = ADC_W'(({1'b0, win_max} + {1'b0, win_min}) >> 1);

        cnt_d = cnt_q;
        min_d = min_q;
        max_d = max_q;
        if (clear || win_done) begin
            cnt_d = '0;
            min_d = '1;
            max_d = '0;
        end else if (sample) begin
            cnt_d = cnt_q + 1'b1;
            min_d = win_min;
            max_d = win_max;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            min_q <= '1;
            max_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            min_q <= min_d;
            max_q <= max_d;
        end
    end

endmodule

// File: rtl/ppg_afe_calibrator.sv
// Per-LED DC/PGA calibration followed by time-multiplexed run mode.
// Optional ambient (all LEDs off) slot in run mode: define PPG_AMBIENT_SLOT_EN.
module ppg_afe_calibrator
    import ppg_afe_pkg::*;
#(
    parameter int NUM_CH       = 2,
    parameter int ADC_W        = 8,
    parameter int DC_W         = 7,
    parameter int PGA_W        = 4,
    parameter int WINDOW       = 20,
    parameter int SLOT_SAMPLES = 10,
    parameter int TARGET_LO    = DEF_TARGET_LO,
    parameter int TARGET_HI    = DEF_TARGET_HI,
    parameter int CLIP_LO      = DEF_CLIP_LO,
    parameter int CLIP_HI      = DEF_CLIP_HI
) (
    input  logic                   CLK,
    input  logic                   rst_n,
    input  logic                   adc_valid,
    input  logic [ADC_W-1:0]       ADC,
    input  logic                   find_setting,
    output logic [NUM_CH-1:0]      LED_EN,
    output logic [DC_W-1:0]        DC_Comp,
    output logic [PGA_W-1:0]       PGA_Gain,
    output logic                   clk_filter,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_CH-1:0]      cal_fail,
    output logic                   sample_valid,
    output logic [SAMPLE_CH_W-1:0] sample_ch,
    output logic [ADC_W-1:0]       sample_data
);

    localparam int CH_IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int SLOT_W   = (SLOT_SAMPLES > 1) ? $clog2(SLOT_SAMPLES) : 1;
`ifdef PPG_AMBIENT_SLOT_EN
    localparam int LAST_SLOT = NUM_CH;
`else
    localparam int LAST_SLOT = NUM_CH - 1;
`endif

    cal_state_t             state_q, state_d;
    logic [SAMPLE_CH_W-1:0] ch_q, ch_d;
    logic [DC_W-1:0]        dc_q, dc_d;
    logic [PGA_W-1:0]       pga_q, pga_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [NUM_CH-1:0]      cal_fail_q, cal_fail_d;
    logic [DC_W-1:0]        dc_reg_q  [NUM_CH];
    logic [DC_W-1:0]        dc_reg_d  [NUM_CH];
    logic [PGA_W-1:0]       pga_reg_q [NUM_CH];
    logic [PGA_W-1:0]       pga_reg_d [NUM_CH];
    logic [SLOT_W-1:0]      slot_q, slot_d;
    logic                   sv_q, sv_d;
    logic [SAMPLE_CH_W-1:0] sch_q, sch_d;
    logic [ADC_W-1:0]       sdata_q, sdata_d;
    logic                   clkf_q, clkf_d;

    logic [CH_IDX_W-1:0]    ch_idx, next_idx;
    logic [SAMPLE_CH_W-1:0] next_ch;
    logic [DC_W-1:0]        next_dc;
    logic [PGA_W-1:0]       next_pga;
    logic                   pga_lock;
    logic                   stat_sample;
    logic                   win_done;
    logic [ADC_W-1:0]       win_min, win_max, win_mid;

    // A restart in the same cycle as a sample drops that sample.
    assign stat_sample = adc_valid && !find_setting &&
                         (state_q == DC_CAL || state_q == PGA_CAL);

    ppg_window_stats #(
        .ADC_W  (ADC_W),
        .WINDOW (WINDOW)
    ) u_stats (
        .CLK      (CLK),
        .rst_n    (rst_n),
        .clear    (find_setting),
        .sample   (stat_sample),
        .din      (ADC),
        .win_done (win_done),
        .win_min  (win_min),
        .win_max  (win_max),
        .win_mid  (win_mid)
    );

    assign ch_idx   = ch_q[CH_IDX_W-1:0];
    assign next_ch  = (ch_q == SAMPLE_CH_W'(LAST_SLOT)) ? '0 : ch_q + 1'b1;
    assign next_idx = next_ch[CH_IDX_W-1:0];
    // The ambient slot (channel index NUM_CH) runs dark with channel 0's gain.
    assign next_dc  = (next_ch < SAMPLE_CH_W'(NUM_CH)) ? dc_reg_q[next_idx]  : '0;
    assign next_pga = (next_ch < SAMPLE_CH_W'(NUM_CH)) ? pga_reg_q[next_idx] : pga_reg_q[0];

    always_comb begin
        LED_EN = '0;
        if (state_q == DC_CAL || state_q == PGA_CAL ||
            (state_q == RUN && ch_q < SAMPLE_CH_W'(NUM_CH)))
            LED_EN[ch_idx] = 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        dc_d       = dc_q;
        pga_d      = pga_q;
        busy_d     = busy_q;
        done_d     = done_q;
        cal_fail_d = cal_fail_q;
        dc_reg_d   = dc_reg_q;
        pga_reg_d  = pga_reg_q;
        slot_d     = slot_q;
        sv_d       = 1'b0;
        sch_d      = sch_q;
        sdata_d    = sdata_q;
        clkf_d     = ~clkf_q;
        pga_lock   = 1'b0;

        if (find_setting) begin
            state_d    = DC_CAL;
            ch_d       = '0;
            dc_d       = '0;
            pga_d      = '0;
            busy_d     = 1'b1;
            done_d     = 1'b0;
            cal_fail_d = '0;
            slot_d     = '0;
        end else begin
            case (state_q)
                DC_CAL: if (win_done) begin
                    if (win_mid < ADC_W'(TARGET_LO) && dc_q != '0)
                        dc_d = dc_q - 1'b1;
                    else if (win_mid > ADC_W'(TARGET_HI) && !(&dc_q))
                        dc_d = dc_q + 1'b1;
                    else begin
                        // Out of band here means the code hit its end stop.
                        if (win_mid < ADC_W'(TARGET_LO) || win_mid > ADC_W'(TARGET_HI))
                            cal_fail_d[ch_idx] = 1'b1;
                        dc_reg_d[ch_idx] = dc_q;
                        state_d          = PGA_CAL;
                    end
                end
                PGA_CAL: if (win_done) begin
                    if (win_min <= ADC_W'(CLIP_LO) || win_max >= ADC_W'(CLIP_HI)) begin
                        pga_d    = (pga_q == '0) ? '0 : pga_q - 1'b1;
                        pga_lock = 1'b1;
                    end else if (&pga_q)
                        pga_lock = 1'b1;
                    else
                        pga_d = pga_q + 1'b1;
                    if (pga_lock) begin
                        pga_reg_d[ch_idx] = pga_d;
                        state_d           = NEXT_CH;
                    end
                end
                NEXT_CH: if (ch_q == SAMPLE_CH_W'(NUM_CH - 1)) begin
                    ch_d    = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    dc_d    = dc_reg_q[0];
                    pga_d   = pga_reg_q[0];
                    slot_d  = '0;
                    state_d = RUN;
                end else begin
                    ch_d    = ch_q + 1'b1;
                    dc_d    = '0;
                    pga_d   = '0;
                    state_d = DC_CAL;
                end
                RUN: if (adc_valid) begin
                    // First sample of each slot is a settling sample.
                    if (slot_q != '0) begin
                        sv_d    = 1'b1;
                        sch_d   = ch_q;
                        sdata_d = ADC;
                    end
                    if (slot_q == SLOT_W'(SLOT_SAMPLES - 1)) begin
                        slot_d = '0;
                        ch_d   = next_ch;
                        dc_d   = next_dc;
                        pga_d  = next_pga;
                    end else
                        slot_d = slot_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ch_q       <= '0;
            dc_q       <= '0;
            pga_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cal_fail_q <= '0;
            dc_reg_q   <= '{default: '0};
            pga_reg_q  <= '{default: '0};
            slot_q     <= '0;
            sv_q       <= 1'b0;
            sch_q      <= '0;
            sdata_q    <= '0;
            clkf_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            dc_q       <= dc_d;
            pga_q      <= pga_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cal_fail_q <= cal_fail_d;
            dc_reg_q   <= dc_reg_d;
            pga_reg_q  <= pga_reg_d;
            slot_q     <= slot_d;
            sv_q       <= sv_d;
            sch_q      <= sch_d;
            sdata_q    <= sdata_d;
            clkf_q     <= clkf_d;
        end
    end

    assign DC_Comp      = dc_q;
    assign PGA_Gain     = pga_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign cal_fail     = cal_fail_q;
    assign sample_valid = sv_q;
    assign sample_ch    = sch_q;
    assign sample_data  = sdata_q;
    assign clk_filter   = clkf_q;

endmodule

// File: tb/tb_ppg_afe_calibrator.sv
// Scoreboard bench for ppg_afe_calibrator: closed-loop ADC plant for calibration,
// queued expected samples for run mode.
module tb_ppg_afe_calibrator;
    import ppg_afe_pkg::*;

    localparam int NUM_CH       = 2;
    localparam int ADC_W        = 8;
    localparam int DC_W         = 7;
    localparam int PGA_W        = 4;
    localparam int WINDOW       = 20;
    localparam int SLOT_SAMPLES = 10;
`ifdef PPG_AMBIENT_SLOT_EN
    localparam int NSLOT = NUM_CH + 1;
`else
    localparam int NSLOT = NUM_CH;
`endif

    logic                   CLK = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   adc_valid = 1'b0;
    logic [ADC_W-1:0]       ADC = '0;
    logic                   find_setting = 1'b0;
    logic [NUM_CH-1:0]      LED_EN;
    logic [DC_W-1:0]        DC_Comp;
    logic [PGA_W-1:0]       PGA_Gain;
    logic                   clk_filter;
    logic                   busy;
    logic                   done;
    logic [NUM_CH-1:0]      cal_fail;
    logic                   sample_valid;
    logic [SAMPLE_CH_W-1:0] sample_ch;
    logic [ADC_W-1:0]       sample_data;

    ppg_afe_calibrator #(
        .NUM_CH       (NUM_CH),
        .ADC_W        (ADC_W),
        .DC_W         (DC_W),
        .PGA_W        (PGA_W),
        .WINDOW       (WINDOW),
        .SLOT_SAMPLES (SLOT_SAMPLES)
    ) dut (
        .CLK          (CLK),
        .rst_n        (rst_n),
        .adc_valid    (adc_valid),
        .ADC          (ADC),
        .find_setting (find_setting),
        .LED_EN       (LED_EN),
        .DC_Comp      (DC_Comp),
        .PGA_Gain     (PGA_Gain),
        .clk_filter   (clk_filter),
        .busy         (busy),
        .done         (done),
        .cal_fail     (cal_fail),
        .sample_valid (sample_valid),
        .sample_ch    (sample_ch),
        .sample_data  (sample_data)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [SAMPLE_CH_W-1:0] ch;
        logic [ADC_W-1:0]       data;
    } smp_t;

    smp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_dc  [NUM_CH];
    int   exp_pga [NUM_CH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Plant: mode 1 midpoint 150-10*DC with swing 4<<gain; mode 2 constant 200; mode 3 constant 50.
    function automatic logic [ADC_W-1:0] plant(input int mode, input logic [DC_W-1:0] dc,
                                               input logic [PGA_W-1:0] g, input bit hi);
        int m, s, v;
        case (mode)
            1:       begin m = 150 - 10 * int'(dc); s = 4 << g; end
            2:       begin m = 200; s = 0; end
            default: begin m = 50;  s = 0; end
        endcase
        v = hi ? m + s : m - s;
        if (v < 0)   v = 0;
        if (v > 255) v = 255;
        return ADC_W'(v);
    endfunction

    initial begin : monitor
        smp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sample_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_sample: got ch %0d data 0x%0h, expected no sample",
                             sample_ch, sample_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("sample_ch", 32'(sample_ch), 32'(e.ch));
                    chk("sample_data", 32'(sample_data), 32'(e.data));
                end
            end
        end
    end

    task automatic run_cal(input int mode, input int budget);
        bit hi = 1'b0;
        bit busy_ok = 1'b1;
        int n = 0;
        int first_step = -1;
        find_setting = 1'b1;
        adc_valid    = 1'b1;
        ADC          = plant(mode, DC_Comp, PGA_Gain, hi);
        cyc();
        find_setting = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_done", 32'(done), 32'd0);
        chk("start_led", 32'(LED_EN), 32'd1);
        chk("start_dc", 32'(DC_Comp), 32'd0);
        chk("start_pga", 32'(PGA_Gain), 32'd0);
        chk("start_cal_fail", 32'(cal_fail), 32'd0);
        while (!done && n < budget) begin
            if (!busy) busy_ok = 1'b0;
            if (first_step < 0 && DC_Comp == 7'd1) first_step = n;
            adc_valid = 1'b1;
            ADC       = plant(mode, DC_Comp, PGA_Gain, hi);
            hi        = ~hi;
            cyc();
            n++;
        end
        adc_valid = 1'b0;
        if (mode == 1) chk("first_dc_step_cycle", 32'(first_step), 32'(WINDOW));
        chk("cal_busy_held", 32'(busy_ok), 32'd1);
        chk("cal_done", 32'(done), 32'd1);
        chk("cal_busy_cleared", 32'(busy), 32'd0);
    endtask

    task automatic run_rotation(input int ncyc);
        int ch = 0;
        int pos = 0;
        for (int k = 0; k < ncyc; k++) begin
            chk("run_led", 32'(LED_EN), (ch < NUM_CH) ? (32'd1 << ch) : 32'd0);
            chk("run_dc", 32'(DC_Comp), (ch < NUM_CH) ? 32'(exp_dc[ch]) : 32'd0);
            chk("run_pga", 32'(PGA_Gain), (ch < NUM_CH) ? 32'(exp_pga[ch]) : 32'(exp_pga[0]));
            if (k % 5 == 4) begin
                adc_valid = 1'b0;
                ADC       = 8'hA5;
            end else begin
                adc_valid = 1'b1;
                ADC       = ADC_W'(k * 7 + 3);
                if (pos != 0) exp_q.push_back('{ch: SAMPLE_CH_W'(ch), data: ADC});
                pos++;
                if (pos == SLOT_SAMPLES) begin
                    pos = 0;
                    ch  = (ch + 1) % NSLOT;
                end
            end
            cyc();
        end
        adc_valid = 1'b0;
        cyc();
        cyc();
        chk("run_queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin : main
        int  n;
        bit  hi;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_led", 32'(LED_EN), 32'd0);
        chk("rst_dc", 32'(DC_Comp), 32'd0);
        chk("rst_pga", 32'(PGA_Gain), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cal_fail", 32'(cal_fail), 32'd0);
        chk("rst_sample_valid", 32'(sample_valid), 32'd0);
        chk("rst_sample_ch", 32'(sample_ch), 32'd0);
        chk("rst_sample_data", 32'(sample_data), 32'd0);
        chk("rst_clk_filter", 32'(clk_filter), 32'd0);
        rst_n = 1'b1;
        cyc();
        chk("clk_filter_rise", 32'(clk_filter), 32'd1);
        adc_valid = 1'b1;
        ADC       = 8'h55;
        cyc();
        chk("clk_filter_fall", 32'(clk_filter), 32'd0);
        chk("idle_led", 32'(LED_EN), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        adc_valid = 1'b0;

        // Converging plant: DC locks at 2, gain clips at 5 and locks at 4.
        run_cal(1, 2000);
        chk("conv_cal_fail", 32'(cal_fail), 32'd0);
        for (int i = 0; i < NUM_CH; i++) begin
            exp_dc[i]  = 2;
            exp_pga[i] = 4;
        end
        run_rotation(48);

        // Restart from RUN into a plant that saturates the DC code high.
        run_cal(2, 8000);
        chk("sat_hi_cal_fail", 32'(cal_fail), (32'd1 << NUM_CH) - 32'd1);
        for (int i = 0; i < NUM_CH; i++) begin
            exp_dc[i]  = 127;
            exp_pga[i] = 15;
        end
        run_rotation(25);

        // DC code cannot step below zero.
        run_cal(3, 2000);
        chk("sat_lo_cal_fail", 32'(cal_fail), (32'd1 << NUM_CH) - 32'd1);
        for (int i = 0; i < NUM_CH; i++) begin
            exp_dc[i]  = 0;
            exp_pga[i] = 15;
        end
        run_rotation(25);

        // Asynchronous reset in the middle of gain calibration.
        find_setting = 1'b1;
        adc_valid    = 1'b1;
        cyc();
        find_setting = 1'b0;
        n  = 0;
        hi = 1'b0;
        while (PGA_Gain != 4'd2 && n < 1000) begin
            ADC = plant(1, DC_Comp, PGA_Gain, hi);
            hi  = ~hi;
            cyc();
            n++;
        end
        chk("reached_pga_cal", 32'(PGA_Gain), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_led", 32'(LED_EN), 32'd0);
        chk("midrst_dc", 32'(DC_Comp), 32'd0);
        chk("midrst_pga", 32'(PGA_Gain), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_cal_fail", 32'(cal_fail), 32'd0);
        chk("midrst_clk_filter", 32'(clk_filter), 32'd0);
        cyc();
        rst_n     = 1'b1;
        adc_valid = 1'b0;
        cyc();
        chk("postrst_busy", 32'(busy), 32'd0);
        chk("postrst_led", 32'(LED_EN), 32'd0);
        chk("postrst_dc", 32'(DC_Comp), 32'd0);
        chk("postrst_clk_filter", 32'(clk_filter), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
